sram_arbiter: RTL and testbench

Two-port arbiter that shares the single SRAM_Controller between a display read client (port 0, deadline-critical VGA fetch) and a general read/write client (port 1, frame fill or image processing). It sits between the requesters and SRAM_Controller, owns the registered SRAM_address / SRAM_write_data / SRAM_we_n drive, and routes returning read data back to the requester with a per-port valid strobe. Port 0 has fixed priority, with an optional starvation guard for port 1.

---
 rtl/sram_arbiter.sv | 126 ++++++++++++
 tb/tb_sram_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM_Controller between a deadline-critical display
// read client (port 0, fixed priority) and a general read/write client (port 1).
// The arbiter registers the SRAM address/data/write-enable drive and tracks each
// issued read through a return pipeline so the data can be steered back to the
// requester with a per-port valid strobe. An optional starvation guard forces a
// port-1 grant after STARVE_LIMIT consecutive denied cycles.
module sram_arbiter #(
    parameter int STARVE_LIMIT = 0,
    parameter int READ_LATENCY = 3
) (
    input  logic        Clock_50,
    input  logic        Reset,
    input  logic        SRAM_ready,
    input  logic        req_0,
    input  logic [17:0] addr_0,
    input  logic        req_1,
    input  logic        we_n_1,
    input  logic [17:0] addr_1,
    input  logic [15:0] wdata_1,
    input  logic [15:0] SRAM_read_data,
    output logic        gnt_0,
    output logic        gnt_1,
    output logic        rvalid_0,
    output logic        rvalid_1,
    output logic [15:0] rdata,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n
);

    // Guard threshold folded to the counter width; a zero limit disables the guard.
    localparam logic [7:0] LIMIT_C  = STARVE_LIMIT[7:0];
    localparam logic       LIMIT_EN = (STARVE_LIMIT != 0);

    // Starvation counter saturates instead of wrapping so a long denial can
    // never make the guard look satisfied-then-unsatisfied again.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [7:0]              starve_q, starve_d;
    logic                    force_1;

    logic [17:0]             addr_q, addr_d;
    logic [15:0]             wdata_q, wdata_d;
    logic                    we_n_q, we_n_d;

    // Return pipeline: bit 0 is the entry loaded on the grant edge, the top bit
    // is the stage aligned with the SRAM_Controller read data.
    logic [READ_LATENCY-1:0] ret_vld_q, ret_vld_d;
    logic [READ_LATENCY-1:0] ret_port_q, ret_port_d;
    logic                    load_vld;

    // Grant decode: port 0 wins unless port 1 has been starved long enough.
    always_comb begin
        force_1 = LIMIT_EN & (starve_q >= LIMIT_C) & req_1;
        gnt_0   = ~Reset & SRAM_ready & req_0 & ~force_1;
        gnt_1   = ~Reset & SRAM_ready & req_1 & (~req_0 | force_1);
    end

    // Starvation counter next state: clears when port 1 is served or idle,
    // counts denied ready cycles, holds while the controller is not ready.
    always_comb begin
        starve_d = starve_q;
        if (~req_1 | gnt_1) begin
            starve_d = 8'd0;
        end else if (SRAM_ready) begin
            starve_d = sat_inc8(starve_q);
        end
    end

    // SRAM drive next state: capture the granted access, otherwise hold the
    // address/data and keep the write strobe inactive.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_n_d  = 1'b1;
        if (gnt_0) begin
            addr_d = addr_0;
        end else if (gnt_1) begin
            addr_d = addr_1;
            if (!we_n_1) begin
                we_n_d  = 1'b0;
                wdata_d = wdata_1;
            end
        end
    end

    // Return pipeline next state: shifts every cycle (also while not ready) so
    // in-flight reads always complete; writes enter as empty slots.
    always_comb begin
        load_vld   = gnt_0 | (gnt_1 & we_n_1);
        ret_vld_d  = {ret_vld_q[READ_LATENCY-2:0], load_vld};
        ret_port_d = {ret_port_q[READ_LATENCY-2:0], gnt_1};
    end

    // State registers; reset discards in-flight reads and any unpresented write.
    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            starve_q   <= 8'd0;
            addr_q     <= 18'd0;
            wdata_q    <= 16'd0;
            we_n_q     <= 1'b1;
            ret_vld_q  <= '0;
            ret_port_q <= '0;
        end else begin
            starve_q   <= starve_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_n_q     <= we_n_d;
            ret_vld_q  <= ret_vld_d;
            ret_port_q <= ret_port_d;
        end
    end

    // Output steering: the last pipeline stage selects which port sees its data.
    always_comb begin
        SRAM_address    = addr_q;
        SRAM_write_data = wdata_q;
        SRAM_we_n       = we_n_q;
        rvalid_0        = ret_vld_q[READ_LATENCY-1] & ~ret_port_q[READ_LATENCY-1];
        rvalid_1        = ret_vld_q[READ_LATENCY-1] &  ret_port_q[READ_LATENCY-1];
        rdata           = SRAM_read_data;
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: instance A uses strict priority, instance B has a
// starvation limit of 4. Each drives a small SRAM model with a 2-cycle read path.
module tb_sram_arbiter;

    typedef struct packed {
        logic        port;
        logic [15:0] data;
        logic [31:0] due;
    } exp_t;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        SRAM_ready = 1'b1;
    logic        req_0 = 1'b0;
    logic [17:0] addr_0 = '0;
    logic        req_1 = 1'b0;
    logic        we_n_1 = 1'b1;
    logic [17:0] addr_1 = '0;
    logic [15:0] wdata_1 = '0;

    logic        a_gnt0, a_gnt1, a_rv0, a_rv1, a_we_n;
    logic [15:0] a_rdata, a_wdata, a_rd;
    logic [17:0] a_addr;
    logic        b_gnt0, b_gnt1, b_rv0, b_rv1, b_we_n;
    logic [15:0] b_rdata, b_wdata, b_rd;
    logic [17:0] b_addr;

    int checks = 0;
    int errors = 0;
    logic [31:0] cyc = 0;
    logic mon_b_en = 1'b0;
    exp_t qa[$];
    exp_t qb[$];

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_arbiter #(.STARVE_LIMIT(0), .READ_LATENCY(3)) dut_a (
        .Clock_50(clk), .Reset(Reset), .SRAM_ready(SRAM_ready),
        .req_0(req_0), .addr_0(addr_0), .req_1(req_1), .we_n_1(we_n_1),
        .addr_1(addr_1), .wdata_1(wdata_1), .SRAM_read_data(a_rd),
        .gnt_0(a_gnt0), .gnt_1(a_gnt1), .rvalid_0(a_rv0), .rvalid_1(a_rv1),
        .rdata(a_rdata), .SRAM_address(a_addr), .SRAM_write_data(a_wdata),
        .SRAM_we_n(a_we_n));

    sram_arbiter #(.STARVE_LIMIT(4), .READ_LATENCY(3)) dut_b (
        .Clock_50(clk), .Reset(Reset), .SRAM_ready(SRAM_ready),
        .req_0(req_0), .addr_0(addr_0), .req_1(req_1), .we_n_1(we_n_1),
        .addr_1(addr_1), .wdata_1(wdata_1), .SRAM_read_data(b_rd),
        .gnt_0(b_gnt0), .gnt_1(b_gnt1), .rvalid_0(b_rv0), .rvalid_1(b_rv1),
        .rdata(b_rdata), .SRAM_address(b_addr), .SRAM_write_data(b_wdata),
        .SRAM_we_n(b_we_n));

    // Background memory contents: a fixed scramble of the address.
    function automatic logic [15:0] fdat(input logic [17:0] a);
        return a[15:0] ^ 16'hC3A5 ^ {a[17:16], 14'd0};
    endfunction

    // SRAM model for A: remembers the most recent write, 2-cycle read path.
    logic        wr_vld = 1'b0;
    logic [17:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] a_d1 = '0;
    logic [15:0] b_d1 = '0;
    always @(posedge clk) begin
        if (!a_we_n) begin
            wr_vld  <= 1'b1;
            wr_addr <= a_addr;
            wr_data <= a_wdata;
        end
        a_d1 <= (wr_vld && wr_addr == a_addr) ? wr_data : fdat(a_addr);
        a_rd <= a_d1;
        b_d1 <= fdat(b_addr);
        b_rd <= b_d1;
    end

    // Return monitor for A: every rvalid must match the oldest expected read.
    always @(negedge clk) begin
        if (a_rv0 || a_rv1) begin
            exp_t e;
            checks++;
            if (a_rv0 && a_rv1) begin
                errors++;
                $display("FAIL a_rvalid_both cyc=%0d rv0=%b rv1=%b required one-hot", cyc, a_rv0, a_rv1);
            end else if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_rvalid_unexpected cyc=%0d rv0=%b rv1=%b required none", cyc, a_rv0, a_rv1);
            end else begin
                e = qa.pop_front();
                if ({a_rv1, a_rdata, cyc} !== {e.port, e.data, e.due}) begin
                    errors++;
                    $display("FAIL a_return got port=%0d data=%h cyc=%0d required port=%0d data=%h cyc=%0d",
                             a_rv1, a_rdata, cyc, e.port, e.data, e.due);
                end
            end
        end
    end

    // Return monitor for B, active only in the starvation scenario.
    always @(negedge clk) begin
        if (mon_b_en && (b_rv0 || b_rv1)) begin
            exp_t e;
            checks++;
            if (b_rv0 && b_rv1) begin
                errors++;
                $display("FAIL b_rvalid_both cyc=%0d required one-hot", cyc);
            end else if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_rvalid_unexpected cyc=%0d rv0=%b rv1=%b required none", cyc, b_rv0, b_rv1);
            end else begin
                e = qb.pop_front();
                if ({b_rv1, b_rdata, cyc} !== {e.port, e.data, e.due}) begin
                    errors++;
                    $display("FAIL b_return got port=%0d data=%h cyc=%0d required port=%0d data=%h cyc=%0d",
                             b_rv1, b_rdata, cyc, e.port, e.data, e.due);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic port, input logic [15:0] data);
        exp_t e;
        e.port = port; e.data = data; e.due = cyc + 3;
        qa.push_back(e);
    endtask

    task automatic push_b(input logic port, input logic [15:0] data);
        exp_t e;
        e.port = port; e.data = data; e.due = cyc + 3;
        qb.push_back(e);
    endtask

    task automatic do_reset();
        Reset = 1'b1; req_0 = 1'b0; req_1 = 1'b0; we_n_1 = 1'b1; SRAM_ready = 1'b1;
        step();
        step();
        qa.delete();
        qb.delete();
        Reset = 1'b0;
    endtask

    task automatic drain(input string name);
        req_0 = 1'b0; req_1 = 1'b0; we_n_1 = 1'b1;
        repeat (6) step();
        checks++;
        if (qa.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_reads pending=%0d required 0", name, qa.size());
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; req_0 = 1'b1; addr_0 = 18'h5; req_1 = 1'b1; we_n_1 = 1'b1; addr_1 = 18'h7;
        repeat (3) begin
            step();
            @(negedge clk);
            checks++;
            if ({a_gnt0, a_gnt1, b_gnt0, b_gnt1} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_gnt got %b required 0000", {a_gnt0, a_gnt1, b_gnt0, b_gnt1});
            end
            checks++;
            if ({a_we_n, a_addr, a_rv0, a_rv1} !== {1'b1, 18'd0, 2'b00}) begin
                errors++;
                $display("FAIL reset_outputs we_n=%b addr=%h rv=%b%b required we_n=1 addr=0 rv=00",
                         a_we_n, a_addr, a_rv0, a_rv1);
            end
        end
        step();
        Reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_gnt0, a_gnt1} !== 2'b10) begin
            errors++;
            $display("FAIL reset_first_grant got %b required 10", {a_gnt0, a_gnt1});
        end
        push_a(1'b0, fdat(18'h5));
        step();
        drain("reset");
    endtask

    task automatic test_write();
        do_reset();
        step();
        req_1 = 1'b1; we_n_1 = 1'b0; addr_1 = 18'h00010; wdata_1 = 16'hABCD;
        @(negedge clk);
        checks++;
        if ({a_gnt0, a_gnt1} !== 2'b01) begin
            errors++;
            $display("FAIL write_gnt got %b required 01", {a_gnt0, a_gnt1});
        end
        step();
        req_1 = 1'b0; we_n_1 = 1'b1; wdata_1 = 16'h0000;
        @(negedge clk);
        checks++;
        if ({a_addr, a_wdata, a_we_n} !== {18'h00010, 16'hABCD, 1'b0}) begin
            errors++;
            $display("FAIL write_drive got addr=%h data=%h we_n=%b required 00010 abcd 0", a_addr, a_wdata, a_we_n);
        end
        step();
        @(negedge clk);
        checks++;
        if ({a_we_n, a_wdata} !== {1'b1, 16'hABCD}) begin
            errors++;
            $display("FAIL write_release got we_n=%b data=%h required 1 abcd", a_we_n, a_wdata);
        end
        step();
        req_1 = 1'b1; we_n_1 = 1'b1; addr_1 = 18'h00010;
        @(negedge clk);
        checks++;
        if (a_gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL write_readback_gnt got %b required 1", a_gnt1);
        end
        push_a(1'b1, 16'hABCD);
        step();
        drain("write");
    endtask

    task automatic test_back_to_back();
        do_reset();
        step();
        req_1 = 1'b1; we_n_1 = 1'b0; addr_1 = 18'h00020; wdata_1 = 16'h1234;
        @(negedge clk);
        checks++;
        if (a_gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_write_gnt got %b required 1", a_gnt1);
        end
        step();
        req_1 = 1'b0; we_n_1 = 1'b1; req_0 = 1'b1; addr_0 = 18'h00020;
        @(negedge clk);
        checks++;
        if ({a_gnt0, a_we_n, a_addr} !== {1'b1, 1'b0, 18'h00020}) begin
            errors++;
            $display("FAIL b2b_switch got gnt0=%b we_n=%b addr=%h required 1 0 00020", a_gnt0, a_we_n, a_addr);
        end
        push_a(1'b0, 16'h1234);
        step();
        req_0 = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_we_n, a_addr} !== {1'b1, 18'h00020}) begin
            errors++;
            $display("FAIL b2b_read_drive got we_n=%b addr=%h required 1 00020", a_we_n, a_addr);
        end
        drain("b2b");
    endtask

    task automatic test_burst();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step();
            req_0 = 1'b1; addr_0 = 18'(i);
            @(negedge clk);
            checks++;
            if (a_gnt0 !== 1'b1) begin
                errors++;
                $display("FAIL burst_gnt%0d got %b required 1", i, a_gnt0);
            end
            push_a(1'b0, fdat(18'(i)));
        end
        step();
        drain("burst");
    endtask

    task automatic test_strict();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            step();
            req_0 = 1'b1; addr_0 = 18'h00030; req_1 = 1'b1; we_n_1 = 1'b1; addr_1 = 18'h3FFFF;
            @(negedge clk);
            checks++;
            if ({a_gnt0, a_gnt1} !== 2'b10) begin
                errors++;
                $display("FAIL strict_gnt%0d got %b required 10", k, {a_gnt0, a_gnt1});
            end
            push_a(1'b0, fdat(18'h00030));
        end
        step();
        req_0 = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_gnt0, a_gnt1} !== 2'b01) begin
            errors++;
            $display("FAIL strict_release got %b required 01", {a_gnt0, a_gnt1});
        end
        push_a(1'b1, fdat(18'h3FFFF));
        step();
        drain("strict");
    endtask

    task automatic test_starve();
        logic exp1;
        do_reset();
        mon_b_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            req_0 = 1'b1; addr_0 = 18'h00040; req_1 = 1'b1; we_n_1 = 1'b1; addr_1 = 18'h00123;
            @(negedge clk);
            exp1 = (k % 5 == 4);
            checks++;
            if ({b_gnt0, b_gnt1} !== {~exp1, exp1}) begin
                errors++;
                $display("FAIL starve_gnt%0d got %b required %b", k, {b_gnt0, b_gnt1}, {~exp1, exp1});
            end
            push_b(exp1, exp1 ? fdat(18'h00123) : fdat(18'h00040));
            push_a(1'b0, fdat(18'h00040));
        end
        step();
        drain("starve");
        checks++;
        if (qb.size() != 0) begin
            errors++;
            $display("FAIL starve_missing_reads pending=%0d required 0", qb.size());
        end
        mon_b_en = 1'b0;
    endtask

    task automatic test_ready();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            step();
            req_0 = 1'b1; addr_0 = 18'h00050 + 18'(k);
            @(negedge clk);
            checks++;
            if (a_gnt0 !== 1'b1) begin
                errors++;
                $display("FAIL ready_pre_gnt%0d got %b required 1", k, a_gnt0);
            end
            push_a(1'b0, fdat(18'h00050 + 18'(k)));
        end
        for (int k = 0; k < 5; k++) begin
            step();
            SRAM_ready = 1'b0; req_0 = 1'b1; addr_0 = 18'h00060; req_1 = 1'b1; we_n_1 = 1'b1; addr_1 = 18'h00061;
            @(negedge clk);
            checks++;
            if ({a_gnt0, a_gnt1, b_gnt0, b_gnt1} !== 4'b0000) begin
                errors++;
                $display("FAIL ready_low_gnt%0d got %b required 0000", k, {a_gnt0, a_gnt1, b_gnt0, b_gnt1});
            end
        end
        step();
        SRAM_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_gnt0, a_gnt1} !== 2'b10) begin
            errors++;
            $display("FAIL ready_resume got %b required 10", {a_gnt0, a_gnt1});
        end
        push_a(1'b0, fdat(18'h00060));
        step();
        drain("ready");
    endtask

    task automatic test_reset_burst();
        do_reset();
        for (int k = 1; k < 3; k++) begin
            step();
            req_0 = 1'b1; addr_0 = 18'(k);
            @(negedge clk);
            checks++;
            if (a_gnt0 !== 1'b1) begin
                errors++;
                $display("FAIL rstburst_gnt%0d got %b required 1", k, a_gnt0);
            end
        end
        step();
        addr_0 = 18'd3; Reset = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k == 3) begin
                Reset = 1'b0; req_0 = 1'b0;
            end
            @(negedge clk);
            checks++;
            if ({a_rv0, a_rv1, a_gnt0} !== 3'b000) begin
                errors++;
                $display("FAIL rstburst_quiet%0d got rv=%b%b gnt0=%b required 000", k, a_rv0, a_rv1, a_gnt0);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_back_to_back();
        test_burst();
        test_strict();
        test_starve();
        test_ready();
        test_reset_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
